motor_duty_sequencer: RTL and testbench

MOTOR_DUTY_SEQUENCER -- requirements
Module: motor_duty_sequencer

---
 rtl/motor_duty_sequencer.sv | 157 +++++++++++++++
 tb/tb_motor_duty_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_duty_sequencer.sv
// motor_duty_sequencer: ramps left/right PWM duty toward commanded targets,
// inserting a ramp-down and dead interval before any loaded direction reversal.
`default_nettype none

module motor_duty_sequencer #(
  parameter int RAMP_DIV    = 1000,
  parameter int STEP        = 4,
  parameter int DEAD_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_mode,
  input  logic [7:0] cmd_duty,
  input  logic       estop,
  output logic [7:0] duty_l,
  output logic [7:0] duty_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic       busy
);

  localparam int PW = $clog2(RAMP_DIV + 1);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [8:0] STEP9 = 9'(STEP);

  typedef enum logic [1:0] {RUN = 2'd0, DOWN = 2'd1, DEAD = 2'd2, ESTOP = 2'd3} state_t;

  state_t         state, state_n;
  logic [PW-1:0]  presc, presc_n;
  logic [DW-1:0]  dead_cnt, dead_n;
  logic [7:0]     tgt_l, tgt_r, tgt_l_n, tgt_r_n;
  logic [7:0]     pend_l, pend_r, pend_l_n, pend_r_n;
  logic           pdir_l, pdir_r, pdir_l_n, pdir_r_n;
  logic [7:0]     duty_l_n, duty_r_n, ramp_l, ramp_r;
  logic           dir_l_n, dir_r_n, ready_n, busy_n;
  logic [7:0]     nt_l, nt_r;
  logic           nd_l, nd_r, tick, accept, rev_needed;

  // One ramp step in 9-bit arithmetic, snapping to target when within STEP.
  function automatic logic [7:0] ramp(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] c9, t9;
    c9 = {1'b0, cur};
    t9 = {1'b0, tgt};
    if (t9 > c9) ramp = ((t9 - c9) <= STEP9) ? tgt : 8'(c9 + STEP9);
    else         ramp = ((c9 - t9) <= STEP9) ? tgt : 8'(c9 - STEP9);
  endfunction

  always_comb begin
    tick   = (presc == PW'(RAMP_DIV - 1));
    ramp_l = tick ? ramp(duty_l, tgt_l) : duty_l;
    ramp_r = tick ? ramp(duty_r, tgt_r) : duty_r;

    nt_l = 8'd0; nt_r = 8'd0; nd_l = dir_l; nd_r = dir_r;
    case (cmd_mode)
      3'd1:    begin nt_l = cmd_duty; nt_r = cmd_duty; nd_l = 1'b1; nd_r = 1'b1; end
      3'd2:    begin nt_l = cmd_duty; nt_r = cmd_duty; nd_l = 1'b0; nd_r = 1'b0; end
      3'd3:    begin nt_l = cmd_duty; nt_r = cmd_duty; nd_l = 1'b0; nd_r = 1'b1; end
      3'd4:    begin nt_l = cmd_duty; nt_r = cmd_duty; nd_l = 1'b1; nd_r = 1'b0; end
      default: ;
    endcase

    accept = cmd_valid && cmd_ready && (state == RUN) && !estop;
    // A side counts as loaded if it is nonzero now or would leave zero on this edge.
    rev_needed = ((nd_l != dir_l) && ((duty_l != 8'd0) || (ramp_l != 8'd0))) ||
                 ((nd_r != dir_r) && ((duty_r != 8'd0) || (ramp_r != 8'd0)));

    state_n  = state;
    presc_n  = tick ? '0 : presc + PW'(1);
    dead_n   = dead_cnt;
    duty_l_n = duty_l;   duty_r_n = duty_r;
    dir_l_n  = dir_l;    dir_r_n  = dir_r;
    tgt_l_n  = tgt_l;    tgt_r_n  = tgt_r;
    pend_l_n = pend_l;   pend_r_n = pend_r;
    pdir_l_n = pdir_l;   pdir_r_n = pdir_r;

    if (estop) begin
      state_n  = ESTOP;
      duty_l_n = 8'd0;  duty_r_n = 8'd0;
      tgt_l_n  = 8'd0;  tgt_r_n  = 8'd0;
      dead_n   = '0;
    end else begin
      case (state)
        RUN: begin
          duty_l_n = ramp_l;
          duty_r_n = ramp_r;
          if (accept) begin
            if (rev_needed) begin
              state_n  = DOWN;
              tgt_l_n  = 8'd0;  tgt_r_n  = 8'd0;
              pend_l_n = nt_l;  pend_r_n = nt_r;
              pdir_l_n = nd_l;  pdir_r_n = nd_r;
            end else begin
              tgt_l_n = nt_l;  tgt_r_n = nt_r;
              dir_l_n = nd_l;  dir_r_n = nd_r;
            end
          end
        end
        DOWN: begin
          duty_l_n = ramp_l;
          duty_r_n = ramp_r;
          if ((ramp_l == 8'd0) && (ramp_r == 8'd0)) begin
            state_n = DEAD;
            dead_n  = '0;
          end
        end
        DEAD: begin
          if (dead_cnt == DW'(DEAD_CYCLES - 1)) begin
            state_n = RUN;
            dead_n  = '0;
            dir_l_n = pdir_l;  dir_r_n = pdir_r;
            tgt_l_n = pend_l;  tgt_r_n = pend_r;
          end else begin
            dead_n = dead_cnt + DW'(1);
          end
        end
        default: begin
          state_n = RUN;
          tgt_l_n = 8'd0;  tgt_r_n = 8'd0;
        end
      endcase
    end

    ready_n = (state_n == RUN);
    busy_n  = (state_n != RUN) || (duty_l_n != tgt_l_n) || (duty_r_n != tgt_r_n);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      presc     <= '0;
      dead_cnt  <= '0;
      duty_l    <= 8'd0;  duty_r <= 8'd0;
      dir_l     <= 1'b1;  dir_r  <= 1'b1;
      tgt_l     <= 8'd0;  tgt_r  <= 8'd0;
      pend_l    <= 8'd0;  pend_r <= 8'd0;
      pdir_l    <= 1'b1;  pdir_r <= 1'b1;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      dead_cnt  <= dead_n;
      duty_l    <= duty_l_n;  duty_r <= duty_r_n;
      dir_l     <= dir_l_n;   dir_r  <= dir_r_n;
      tgt_l     <= tgt_l_n;   tgt_r  <= tgt_r_n;
      pend_l    <= pend_l_n;  pend_r <= pend_r_n;
      pdir_l    <= pdir_l_n;  pdir_r <= pdir_r_n;
      cmd_ready <= ready_n;
      busy      <= busy_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_motor_duty_sequencer.sv
// Directed bench for motor_duty_sequencer: small-parameter ramp, reversal, estop and reset cases.
`default_nettype none

module tb_motor_duty_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_mode = 3'd0;
  logic [7:0] cmd_duty = 8'd0;
  logic       estop = 1'b0;
  logic [7:0] duty_l, duty_r;
  logic       dir_l, dir_r, busy;

  logic       b_cmd_valid = 1'b0, b_cmd_ready;
  logic [2:0] b_cmd_mode = 3'd0;
  logic [7:0] b_cmd_duty = 8'd0;
  logic [7:0] b_duty_l, b_duty_r;
  logic       b_dir_l, b_dir_r, b_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int last_gap = 0;

  always #5 clk = ~clk;

  motor_duty_sequencer #(.RAMP_DIV(4), .STEP(4), .DEAD_CYCLES(8)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_duty(cmd_duty), .estop(estop),
    .duty_l(duty_l), .duty_r(duty_r), .dir_l(dir_l), .dir_r(dir_r), .busy(busy)
  );

  motor_duty_sequencer #(.RAMP_DIV(4), .STEP(255), .DEAD_CYCLES(8)) u_big (
    .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_mode(b_cmd_mode), .cmd_duty(b_cmd_duty), .estop(1'b0),
    .duty_l(b_duty_l), .duty_r(b_duty_r), .dir_l(b_dir_l), .dir_r(b_dir_r), .busy(b_busy)
  );

  task automatic check(input string tag, input int got, input int exp_v);
    n_checks++;
    if (got != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] mode, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_duty  = d;
    check("send_ready", int'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_l(input string tag, input int exp_v);
    logic [7:0] old;
    int n;
    old = duty_l;
    n = 0;
    while (duty_l == old && n < 64) begin
      step();
      n++;
    end
    last_gap = n;
    check(tag, int'(duty_l), exp_v);
  endtask

  initial begin
    logic [7:0] bold;
    int n;

    // reset values
    repeat (3) step();
    check("rst_duty_l", int'(duty_l), 0);
    check("rst_duty_r", int'(duty_r), 0);
    check("rst_dir_l", int'(dir_l), 1);
    check("rst_dir_r", int'(dir_r), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_ready), 0);
    reset = 1'b1;
    step();
    check("post_rst_ready", int'(cmd_ready), 1);

    // fwd 10 from rest
    send(3'd1, 8'd10);
    check("fwd_busy", int'(busy), 1);
    wait_l("fwd_t1", 4);
    check("fwd_t1_r", int'(duty_r), 4);
    wait_l("fwd_t2", 8);
    check("fwd_gap", last_gap, 4);
    wait_l("fwd_t3", 10);
    check("fwd_t3_r", int'(duty_r), 10);
    check("fwd_done_busy", int'(busy), 0);
    check("fwd_dir", int'(dir_l), 1);

    // loaded reversal: ramp down, dead interval, ramp up reversed
    send(3'd2, 8'd6);
    check("rev_ready", int'(cmd_ready), 0);
    check("rev_dir_hold", int'(dir_l), 1);
    wait_l("rev_d1", 6);
    wait_l("rev_d2", 2);
    wait_l("rev_d3", 0);
    check("rev_dir_at0", int'(dir_l), 1);
    n = 0;
    while (dir_l == 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("dead_len", n, 8);
    check("dead_exit_ready", int'(cmd_ready), 1);
    check("rev_dir_r", int'(dir_r), 0);
    check("dead_exit_duty", int'(duty_l), 0);
    wait_l("rev_u1", 4);
    wait_l("rev_u2", 6);
    check("rev_u2_r", int'(duty_r), 6);

    // stop, then a direction change on idle sides applies immediately
    send(3'd0, 8'd99);
    wait_l("stop_d1", 2);
    wait_l("stop_d2", 0);
    check("stop_dir", int'(dir_l), 0);
    send(3'd4, 8'd8);
    check("spin_dir_l", int'(dir_l), 1);
    check("spin_dir_r", int'(dir_r), 0);
    check("spin_ready", int'(cmd_ready), 1);
    wait_l("spin_u1", 4);
    wait_l("spin_u2", 8);
    check("spin_r", int'(duty_r), 8);

    // estop mid-ramp at 200 with a competing command
    send(3'd4, 8'd250);
    n = 0;
    while (duty_l != 8'd200 && n < 500) begin
      step();
      n++;
    end
    check("reach_200", int'(duty_l), 200);
    estop     = 1'b1;
    cmd_valid = 1'b1;
    cmd_mode  = 3'd1;
    cmd_duty  = 8'd50;
    step();
    estop     = 1'b0;
    cmd_valid = 1'b0;
    check("estop_duty_l", int'(duty_l), 0);
    check("estop_duty_r", int'(duty_r), 0);
    check("estop_ready", int'(cmd_ready), 0);
    check("estop_busy", int'(busy), 1);
    step();
    check("estop_rel_ready", int'(cmd_ready), 1);
    check("estop_rel_busy", int'(busy), 0);
    check("estop_dir_r", int'(dir_r), 0);
    repeat (10) step();
    check("estop_no_cmd", int'(duty_l), 0);

    // reset during DEAD drops the pending reversal
    send(3'd1, 8'd8);
    check("idle_dir_r", int'(dir_r), 1);
    wait_l("pre_u1", 4);
    wait_l("pre_u2", 8);
    send(3'd2, 8'd8);
    wait_l("pre_d1", 4);
    wait_l("pre_d2", 0);
    repeat (3) step();
    reset = 1'b0;
    step();
    check("dead_rst_duty", int'(duty_l), 0);
    check("dead_rst_dir_l", int'(dir_l), 1);
    check("dead_rst_dir_r", int'(dir_r), 1);
    check("dead_rst_busy", int'(busy), 0);
    check("dead_rst_ready", int'(cmd_ready), 0);
    reset = 1'b1;
    repeat (20) step();
    check("no_pending_dir", int'(dir_l), 1);
    check("no_pending_duty", int'(duty_l), 0);

    // full-scale single-tick ramp with STEP=255
    b_cmd_valid = 1'b1;
    b_cmd_mode  = 3'd1;
    b_cmd_duty  = 8'd255;
    check("big_ready", int'(b_cmd_ready), 1);
    step();
    b_cmd_valid = 1'b0;
    bold = b_duty_l;
    n = 0;
    while (b_duty_l == bold && n < 10) begin
      step();
      n++;
    end
    check("big_up_l", int'(b_duty_l), 255);
    check("big_up_r", int'(b_duty_r), 255);
    check("big_up_busy", int'(b_busy), 0);
    b_cmd_valid = 1'b1;
    b_cmd_mode  = 3'd0;
    step();
    b_cmd_valid = 1'b0;
    bold = b_duty_l;
    n = 0;
    while (b_duty_l == bold && n < 10) begin
      step();
      n++;
    end
    check("big_down_l", int'(b_duty_l), 0);
    check("big_down_r", int'(b_duty_r), 0);
    check("big_dir", int'(b_dir_l), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
